gpr_file_sb: RTL and testbench

Parametrised general-purpose register file with an outstanding-load scoreboard, successor to the fixed 8×16 register file of the single-cycle RISC16 core. It serves the multi-cycle/pipelined core generation: N combinational read ports with same-cycle write bypass, a primary writeback port, a dedicated link (`$ra`) port for `jal`, and per-register pending bits so issue logic can stall on registers awaiting a multi-cycle load. Sits between decode (read/issue) and writeback.

---
 rtl/gpr_file_sb.sv | 101 ++++++++++
 tb/tb_gpr_file_sb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file_sb.sv
// Parametrised general-purpose register file with bypassed read ports, a link port,
// and a scoreboard of registers awaiting multi-cycle loads.
module gpr_file_sb #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int NRD       = 3,
    parameter int RA_IDX    = 5,
    parameter int SP_IDX    = 6,
    parameter int SP_RESET  = 128,
    parameter int ZERO_HARD = 1,
    parameter int MAX_PEND  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            link_en,
    input  logic [DATA_W-1:0]               link_data,
    input  logic [NRD*ADDR_W-1:0]           rd_addr,
    output logic [NRD*DATA_W-1:0]           rd_data,
    output logic [NRD-1:0]                  rd_busy,
    input  logic                            issue_en,
    input  logic [ADDR_W-1:0]               issue_addr,
    output logic                            issue_ready,
    output logic [(2**ADDR_W)-1:0]          pending,
    output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt,
    output logic                            sb_err
);
    localparam int NREGS = 2**ADDR_W;
    localparam int CNT_W = $clog2(MAX_PEND+1);
    localparam logic [ADDR_W-1:0] RA_A  = ADDR_W'(RA_IDX);
    localparam logic [CNT_W-1:0]  MAX_C = CNT_W'(MAX_PEND);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_ok, link_ok, iss_ok, iss_hit, clr, set, err;
    logic [NREGS-1:0]  clr_vec, set_vec;
    logic [ADDR_W-1:0] ra;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_HARD != 0) && (a == '0);
    endfunction

    assign issue_ready = (pend_cnt < MAX_C);

    // A write that clears the very bit being issued turns a would-be error into clear+set.
    always_comb begin
        wr_ok   = wr_en && !is_zero(wr_addr);
        link_ok = link_en && !is_zero(RA_A);
        clr     = wr_ok && pending[wr_addr];
        iss_ok  = issue_en && issue_ready && !is_zero(issue_addr);
        iss_hit = clr && (wr_addr == issue_addr);
        set     = iss_ok && (!pending[issue_addr] || iss_hit);
        err     = iss_ok && pending[issue_addr] && !iss_hit;
        clr_vec = '0;
        set_vec = '0;
        if (clr) clr_vec[wr_addr] = 1'b1;
        if (set) set_vec[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
        end else begin
            if (wr_ok) regs[wr_addr] <= wr_data;
            if (link_ok) regs[RA_A] <= link_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
            sb_err   <= 1'b0;
        end else begin
            pending  <= (pending & ~clr_vec) | set_vec;
            pend_cnt <= pend_cnt + CNT_W'(set) - CNT_W'(clr);
            if (err) sb_err <= 1'b1;
        end
    end

    // Bypass is suppressed during reset so reads reflect the array being cleared.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            if (!is_zero(ra)) begin
                if (!rst && link_en && ra == RA_A)
                    rd_data[i*DATA_W +: DATA_W] = link_data;
                else if (!rst && wr_en && ra == wr_addr)
                    rd_data[i*DATA_W +: DATA_W] = wr_data;
                else
                    rd_data[i*DATA_W +: DATA_W] = regs[ra];
                rd_busy[i] = pending[ra] && !(wr_en && wr_addr == ra);
            end
        end
    end
endmodule

// File: tb/tb_gpr_file_sb.sv
// Scenario bench for gpr_file_sb: expected values queued at stimulus time and
// popped when the corresponding DUT output is sampled.
module tb_gpr_file_sb;
    localparam int DW = 16, AW = 3, NRD = 3, NREGS = 8;

    logic                clk = 1'b0;
    logic                rst, wr_en, link_en, issue_en;
    logic [AW-1:0]       wr_addr, issue_addr;
    logic [DW-1:0]       wr_data, link_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                issue_ready;
    logic [NREGS-1:0]    pending;
    logic [2:0]          pend_cnt;
    logic                sb_err;

    int          n_pass = 0, n_total = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    always #5 clk = ~clk;

    gpr_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .RA_IDX(5), .SP_IDX(6),
                  .SP_RESET(128), .ZERO_HARD(1), .MAX_PEND(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .link_en(link_en), .link_data(link_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .issue_en(issue_en), .issue_addr(issue_addr),
        .issue_ready(issue_ready), .pending(pending), .pend_cnt(pend_cnt), .sb_err(sb_err));

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        link_en = 0; link_data = 0;
        issue_en = 0; issue_addr = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] port(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic test_reset();
        rst = 1; idle(); rd_addr = '0;
        tick();
        wr_en = 1; wr_addr = 1; wr_data = 16'h5555; set_rd(0, 1);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(0)) !== e) $display("FAIL rst_no_bypass: got %0h expected %0h", port(0), e); else n_pass++;
        tick();
        rst = 0; idle();
        for (int r = 0; r < NREGS; r++) begin
            set_rd(0, AW'(r));
            exp_q.push_back((r == 6) ? 32'd128 : 32'd0);
            #1;
            e = exp_q.pop_front(); n_total++;
            if (32'(port(0)) !== e) $display("FAIL reset_reg%0d: got %0h expected %0h", r, port(0), e); else n_pass++;
        end
        exp_q.push_back(32'h0); exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_total++;
        if (32'(pending) !== e) $display("FAIL reset_pending: got %0h expected %0h", pending, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(issue_ready) !== e) $display("FAIL reset_ready: got %0h expected %0h", issue_ready, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL reset_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(sb_err) !== e) $display("FAIL reset_err: got %0h expected %0h", sb_err, e); else n_pass++;
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 5; wr_data = 16'h1111;
        link_en = 1; link_data = 16'h0024; set_rd(1, 5);
        exp_q.push_back(32'h0024);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(1)) !== e) $display("FAIL link_bypass: got %0h expected %0h", port(1), e); else n_pass++;
        tick(); idle();
        exp_q.push_back(32'h0024);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(1)) !== e) $display("FAIL link_wins: got %0h expected %0h", port(1), e); else n_pass++;
        wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF; set_rd(0, 0);
        wr_en = 1;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(0)) !== e) $display("FAIL zero_bypass: got %0h expected %0h", port(0), e); else n_pass++;
        tick(); idle();
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(0)) !== e) $display("FAIL zero_array: got %0h expected %0h", port(0), e); else n_pass++;
        wr_en = 1; wr_addr = 2; wr_data = 16'hBEEF; set_rd(2, 2);
        exp_q.push_back(32'hBEEF);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(2)) !== e) $display("FAIL wr_bypass: got %0h expected %0h", port(2), e); else n_pass++;
        tick(); idle();
        exp_q.push_back(32'hBEEF);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(2)) !== e) $display("FAIL wr_array: got %0h expected %0h", port(2), e); else n_pass++;
    endtask

    task automatic test_stall();
        issue_en = 1; issue_addr = 3; set_rd(2, 3);
        exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h08);
        tick(); idle(); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(rd_busy[2]) !== e) $display("FAIL stall_busy: got %0h expected %0h", rd_busy[2], e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL stall_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pending) !== e) $display("FAIL stall_pending: got %0h expected %0h", pending, e); else n_pass++;
        wr_en = 1; wr_addr = 3; wr_data = 16'h00AB;
        exp_q.push_back(32'h0); exp_q.push_back(32'h00AB);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(rd_busy[2]) !== e) $display("FAIL release_busy: got %0h expected %0h", rd_busy[2], e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(2)) !== e) $display("FAIL release_data: got %0h expected %0h", port(2), e); else n_pass++;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        tick(); idle(); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(pending[3]) !== e) $display("FAIL release_pending: got %0h expected %0h", pending[3], e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL release_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
    endtask

    task automatic test_full();
        for (int r = 1; r <= 4; r++) begin
            issue_en = 1; issue_addr = AW'(r);
            tick();
        end
        idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h1E);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(issue_ready) !== e) $display("FAIL full_ready: got %0h expected %0h", issue_ready, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL full_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pending) !== e) $display("FAIL full_pending: got %0h expected %0h", pending, e); else n_pass++;
        issue_en = 1; issue_addr = 7;
        exp_q.push_back(32'h1E); exp_q.push_back(32'h4);
        tick(); idle(); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(pending) !== e) $display("FAIL full_drop_pending: got %0h expected %0h", pending, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL full_drop_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
        issue_en = 1; issue_addr = 2;
        exp_q.push_back(32'h0);
        tick(); idle(); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(sb_err) !== e) $display("FAIL full_no_err: got %0h expected %0h", sb_err, e); else n_pass++;
        wr_en = 1; wr_addr = 2; wr_data = 16'h2222;
        exp_q.push_back(32'h3); exp_q.push_back(32'h1); exp_q.push_back(32'h1A);
        tick(); idle(); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL drain_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(issue_ready) !== e) $display("FAIL drain_ready: got %0h expected %0h", issue_ready, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pending) !== e) $display("FAIL drain_pending: got %0h expected %0h", pending, e); else n_pass++;
        for (int r = 1; r <= 4; r++) begin
            if (r != 2) begin
                wr_en = 1; wr_addr = AW'(r); wr_data = 16'(r);
                tick();
            end
        end
        idle();
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL cleanup_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
    endtask

    task automatic test_collision();
        issue_en = 1; issue_addr = 4; wr_en = 1; wr_addr = 4; wr_data = 16'h4444;
        exp_q.push_back(32'h10); exp_q.push_back(32'h1); exp_q.push_back(32'h4444);
        tick(); idle(); set_rd(0, 4); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(pending) !== e) $display("FAIL coll_pending: got %0h expected %0h", pending, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL coll_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(0)) !== e) $display("FAIL coll_data: got %0h expected %0h", port(0), e); else n_pass++;
        issue_en = 1; issue_addr = 4; wr_en = 1; wr_addr = 4; wr_data = 16'h4545;
        exp_q.push_back(32'h10); exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h4545);
        tick(); idle(); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(pending) !== e) $display("FAIL clrset_pending: got %0h expected %0h", pending, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL clrset_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(sb_err) !== e) $display("FAIL clrset_err: got %0h expected %0h", sb_err, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(0)) !== e) $display("FAIL clrset_data: got %0h expected %0h", port(0), e); else n_pass++;
        issue_en = 1; issue_addr = 4;
        exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        tick(); idle(); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(sb_err) !== e) $display("FAIL dup_err: got %0h expected %0h", sb_err, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL dup_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
        issue_en = 1; issue_addr = 0;
        exp_q.push_back(32'h10); exp_q.push_back(32'h1);
        tick(); idle(); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(pending) !== e) $display("FAIL zero_issue_pending: got %0h expected %0h", pending, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(sb_err) !== e) $display("FAIL err_sticky: got %0h expected %0h", sb_err, e); else n_pass++;
    endtask

    task automatic test_reset_mid();
        issue_en = 1; issue_addr = 1; tick();
        issue_en = 1; issue_addr = 2;
        exp_q.push_back(32'h3); exp_q.push_back(32'h16);
        tick(); idle(); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL pre_rst_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pending) !== e) $display("FAIL pre_rst_pending: got %0h expected %0h", pending, e); else n_pass++;
        rst = 1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        tick(); rst = 0; idle(); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(pending) !== e) $display("FAIL mid_rst_pending: got %0h expected %0h", pending, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL mid_rst_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(sb_err) !== e) $display("FAIL mid_rst_err: got %0h expected %0h", sb_err, e); else n_pass++;
        wr_en = 1; wr_addr = 1; wr_data = 16'h7777;
        exp_q.push_back(32'h7777); exp_q.push_back(32'h0); exp_q.push_back(32'd128);
        tick(); idle(); set_rd(0, 1); set_rd(1, 6); #1;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(0)) !== e) $display("FAIL inflight_data: got %0h expected %0h", port(0), e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(pend_cnt) !== e) $display("FAIL inflight_cnt: got %0h expected %0h", pend_cnt, e); else n_pass++;
        e = exp_q.pop_front(); n_total++;
        if (32'(port(1)) !== e) $display("FAIL mid_rst_sp: got %0h expected %0h", port(1), e); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_stall();
        test_full();
        test_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
